// File: rtl/maze_pkg.sv
// Shared maze definitions: game-state codes, direction codes, map geometry,
// the 40x40 wall map (also read by the renderer) and the move FSM state type.
package maze_pkg;

    localparam logic [3:0] ST_TITLE    = 4'd0;
    localparam logic [3:0] ST_STAFF    = 4'd1;
    localparam logic [3:0] ST_STAGE1   = 4'd2;
    localparam logic [3:0] ST_SUCCESS1 = 4'd3;
    localparam logic [3:0] ST_STAGE2   = 4'd4;
    localparam logic [3:0] ST_SUCCESS2 = 4'd5;
    localparam logic [3:0] ST_STAGE3   = 4'd6;
    localparam logic [3:0] ST_SUCCESS3 = 4'd7;
    localparam logic [3:0] ST_FAIL     = 4'd8;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam int MAP_W     = 40;
    localparam int MAP_H     = 40;
    localparam int PLAYER_SZ = 4;

    typedef enum logic [1:0] {
        MV_IDLE  = 2'd0,
        MV_CHECK = 2'd1,
        MV_DONE  = 2'd2
    } move_state_t;

    // Border walls all round, an opening in the left border on rows 18..21,
    // and an internal wall on column 19 spanning rows 1..10.
    function automatic logic [MAP_H-1:0][MAP_W-1:0] build_wall_map();
        logic [MAP_H-1:0][MAP_W-1:0] m;
        for (int r = 0; r < MAP_H; r++) begin
            m[r] = '0;
            if (r == 0 || r == MAP_H - 1) begin
                m[r] = '1;
            end else begin
                m[r][MAP_W-1] = 1'b1;
                m[r][0]       = !(r >= 18 && r <= 21);
                if (r <= 10) m[r][19] = 1'b1;
            end
        end
        return m;
    endfunction

    // Row word r, bit c (LSB = column 0) is wall(r, c).
    localparam logic [MAP_H-1:0][MAP_W-1:0] WALL_MAP = build_wall_map();

    function automatic logic is_stage(input logic [3:0] s);
        return (s == ST_STAGE1) || (s == ST_STAGE2) || (s == ST_STAGE3);
    endfunction

endpackage

// File: rtl/player_move_ctrl_if.sv
// Move request / status bundle between the input decoder and player_move_ctrl.
// Optional step_count member exists only with PLAYER_MOVE_STEP_COUNT_EN.
//
// Handshake: move_req is a single-cycle pulse with dir valid in the same
// cycle; it is taken only when busy=0 and the game is in a stage, otherwise
// it is dropped (no back-pressure, no retry). Every taken request ends with
// exactly one move_done pulse, with blocked high in that cycle if rejected,
// unless a reset or stage entry discards it.
interface player_move_ctrl_if;
    logic       move_req;
    logic [1:0] dir;
    logic [5:0] player_x;
    logic [5:0] player_y;
    logic       busy;
    logic       move_done;
    logic       blocked;
`ifdef PLAYER_MOVE_STEP_COUNT_EN
    logic [9:0] step_count;

    modport master (output move_req, dir,
                    input  player_x, player_y, busy, move_done, blocked, step_count);
    modport slave  (input  move_req, dir,
                    output player_x, player_y, busy, move_done, blocked, step_count);
`else
    modport master (output move_req, dir,
                    input  player_x, player_y, busy, move_done, blocked);
    modport slave  (input  move_req, dir,
                    output player_x, player_y, busy, move_done, blocked);
`endif
endinterface

// File: rtl/maze_wall_lookup.sv
// Combinational wall lookup: (row, col) -> wall bit; anything off the map is wall.
module maze_wall_lookup
    import maze_pkg::*;
(
    input  logic [5:0] row,
    input  logic [5:0] col,
    output logic       wall
);

    // Off-map coordinates read as wall so range errors can never open a gap.
    always_comb begin
        wall = 1'b1;
        if (row < 6'(MAP_H) && col < 6'(MAP_W)) wall = WALL_MAP[row][col];
    end

endmodule

// File: rtl/player_move_ctrl.sv
// Player footprint movement with wall/edge rejection.
// Optional: PLAYER_MOVE_STEP_COUNT_EN adds a saturating committed-move counter.
module player_move_ctrl
    import maze_pkg::*;
#(
    parameter int START_X = 1,
    parameter int START_Y = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               state,
    player_move_ctrl_if.slave        bus,
    output move_state_t              fsm_dbg
);

    localparam logic [5:0] POS_MAX = 6'(MAP_W - PLAYER_SZ);

    move_state_t fsm_q, fsm_d;
    logic [3:0]  state_q;
    logic [5:0]  x_q, y_q;
    logic [1:0]  dir_q, idx_q;
    logic        hit_q, done_q, blocked_q;
    logic [5:0]  chk_row, chk_col;
    logic        wall;
    logic        in_stage, stage_entry, accept, oob;

    assign in_stage    = is_stage(state);
    assign stage_entry = in_stage && (state != state_q);
    assign accept      = (fsm_q == MV_IDLE) && in_stage && !stage_entry && bus.move_req;

    // Edge-of-map rejection for the requested direction at the current position.
    always_comb begin
        oob = 1'b0;
        case (bus.dir)
            DIR_UP:    oob = (y_q == 6'd0);
            DIR_DOWN:  oob = (y_q == POS_MAX);
            DIR_LEFT:  oob = (x_q == 6'd0);
            default:   oob = (x_q == POS_MAX);
        endcase
    end

    // Address of the idx-th newly entered cell for the latched direction.
    always_comb begin
        chk_row = y_q + {4'd0, idx_q};
        chk_col = x_q + {4'd0, idx_q};
        case (dir_q)
            DIR_UP:    chk_row = y_q - 6'd1;
            DIR_DOWN:  chk_row = y_q + 6'd4;
            DIR_LEFT:  chk_col = x_q - 6'd1;
            default:   chk_col = x_q + 6'd4;
        endcase
    end

    maze_wall_lookup u_lookup (
        .row  (chk_row),
        .col  (chk_col),
        .wall (wall)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fsm_q <= MV_IDLE;
        else     fsm_q <= fsm_d;
    end

    // Next state; leaving a stage or entering a new one discards any check.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            MV_IDLE:  if (accept) fsm_d = oob ? MV_DONE : MV_CHECK;
            MV_CHECK: if (idx_q == 2'd3) fsm_d = MV_DONE;
            MV_DONE:  fsm_d = MV_IDLE;
            default:  fsm_d = MV_IDLE;
        endcase
        if (!in_stage || stage_entry) fsm_d = MV_IDLE;
    end

    // Position, latched request, sticky wall flag and completion pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_TITLE;
            x_q       <= 6'(START_X);
            y_q       <= 6'(START_Y);
            dir_q     <= DIR_UP;
            idx_q     <= 2'd0;
            hit_q     <= 1'b0;
            done_q    <= 1'b0;
            blocked_q <= 1'b0;
        end else begin
            state_q   <= state;
            done_q    <= 1'b0;
            blocked_q <= 1'b0;
            if (stage_entry) begin
                x_q   <= 6'(START_X);
                y_q   <= 6'(START_Y);
                idx_q <= 2'd0;
                hit_q <= 1'b0;
            end else begin
                case (fsm_q)
                    MV_IDLE: if (accept) begin
                        dir_q <= bus.dir;
                        idx_q <= 2'd0;
                        hit_q <= oob;
                    end
                    MV_CHECK: if (in_stage) begin
                        hit_q <= hit_q | wall;
                        idx_q <= idx_q + 2'd1;
                    end
                    MV_DONE: if (in_stage) begin
                        done_q    <= 1'b1;
                        blocked_q <= hit_q;
                        if (!hit_q) begin
                            case (dir_q)
                                DIR_UP:   y_q <= y_q - 6'd1;
                                DIR_DOWN: y_q <= y_q + 6'd1;
                                DIR_LEFT: x_q <= x_q - 6'd1;
                                default:  x_q <= x_q + 6'd1;
                            endcase
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef PLAYER_MOVE_STEP_COUNT_EN
    logic [9:0] steps_q;

    // Count committed moves, saturating, cleared on stage entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 steps_q <= 10'd0;
        else if (stage_entry)    steps_q <= 10'd0;
        else if (fsm_q == MV_DONE && in_stage && !hit_q && steps_q != 10'd1023)
                                 steps_q <= steps_q + 10'd1;
    end

    assign bus.step_count = steps_q;
`endif

    assign bus.player_x  = x_q;
    assign bus.player_y  = y_q;
    assign bus.busy      = (fsm_q != MV_IDLE);
    assign bus.move_done = done_q;
    assign bus.blocked   = blocked_q;
    assign fsm_dbg       = fsm_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Bench for player_move_ctrl: move table through the maze plus hand-written
// corner sequences (dropped requests, stage entry and reset mid-check).
module tb_player_move_ctrl;
    import maze_pkg::*;

    logic        clk;
    logic        rst;
    logic [3:0]  state;
    move_state_t fsm_dbg;

    player_move_ctrl_if bus ();

    player_move_ctrl #(.START_X(1), .START_Y(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .state   (state),
        .bus     (bus),
        .fsm_dbg (fsm_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;
    logic [12:0] exp_q[$];   // {blocked, player_x, player_y} at move_done

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Compare every move_done against the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [12:0] e;
        if (bus.move_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got move_done=1 expected none at x=%0d y=%0d",
                         bus.player_x, bus.player_y);
            end else begin
                e = exp_q.pop_front();
                check("move_result", {bus.blocked, bus.player_x, bus.player_y}, e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_move(input logic [1:0] d, input logic [5:0] ex, input logic [5:0] ey,
                           input logic eb, input int lat);
        int cycles;
        @(negedge clk);
        bus.move_req = 1'b1;
        bus.dir      = d;
        exp_q.push_back({eb, ex, ey});
        @(posedge clk);
        #1;
        bus.move_req = 1'b0;
        bus.dir      = 2'($urandom_range(0, 3));
        cycles = 0;
        while (bus.move_done !== 1'b1 && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 1 && lat > 1) check("busy_mid", bus.busy, 1);
        end
        check("latency", cycles, lat);
        check("busy_after", bus.busy, 0);
    endtask

    task automatic start_req(input logic [1:0] d);
        @(negedge clk);
        bus.move_req = 1'b1;
        bus.dir      = d;
        @(posedge clk);
        #1;
        bus.move_req = 1'b0;
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (bus.move_done === 1'b1) cnt++;
        end
    endtask

    task automatic set_state(input logic [3:0] s);
        @(negedge clk);
        state = s;
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0] d;
        logic [5:0] ex;
        logic [5:0] ey;
        logic       eb;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [1:0] d, input int ex, input int ey,
                           input logic eb, input int lat);
        vec_t v;
        v.d   = d;
        v.ex  = 6'(ex);
        v.ey  = 6'(ey);
        v.eb  = eb;
        v.lat = lat;
        vecs.push_back(v);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int cnt;

        // Up into the top border, then 14 rights, then the column-19 wall.
        add_vec(DIR_UP, 1, 1, 1'b1, 5);
        for (int i = 2; i <= 15; i++) add_vec(DIR_RIGHT, i, 1, 1'b0, 5);
        add_vec(DIR_RIGHT, 15, 1, 1'b1, 5);
        // Down to the row-18 opening, then left out to column 0.
        for (int i = 2; i <= 18; i++) add_vec(DIR_DOWN, 15, i, 1'b0, 5);
        for (int i = 14; i >= 0; i--) add_vec(DIR_LEFT, i, 18, 1'b0, 5);
        // Left edge of the map: rejected without reading cells.
        add_vec(DIR_LEFT, 0, 18, 1'b1, 1);
        // Down at column 0 runs into the left border below the opening.
        add_vec(DIR_DOWN, 0, 18, 1'b1, 5);

        rst          = 1'b1;
        state        = ST_TITLE;
        bus.move_req = 1'b0;
        bus.dir      = DIR_UP;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_x", bus.player_x, 1);
        check("reset_y", bus.player_y, 1);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.move_done, 0);
        check("reset_blocked", bus.blocked, 0);
        check("reset_fsm", fsm_dbg, MV_IDLE);
        rst = 1'b0;

        // Requests outside a stage are dropped.
        start_req(DIR_RIGHT);
        check("title_busy", bus.busy, 0);
        count_done(8, cnt);
        check("title_no_done", cnt, 0);
        check("title_x", bus.player_x, 1);

        set_state(ST_STAGE1);
        check("stage1_x", bus.player_x, 1);
        check("stage1_y", bus.player_y, 1);
        check("stage1_busy", bus.busy, 0);

        foreach (vecs[i]) do_move(vecs[i].d, vecs[i].ex, vecs[i].ey, vecs[i].eb, vecs[i].lat);

        // Second request while busy is dropped: exactly one move_done.
        @(negedge clk);
        bus.move_req = 1'b1;
        bus.dir      = DIR_RIGHT;
        exp_q.push_back({1'b0, 6'd1, 6'd18});
        @(posedge clk);
        #1;
        bus.move_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("dup_busy", bus.busy, 1);
        bus.move_req = 1'b1;
        bus.dir      = DIR_LEFT;
        @(posedge clk);
        #1;
        bus.move_req = 1'b0;
        count_done(12, cnt);
        check("dup_one_done", cnt, 1);
        check("dup_x", bus.player_x, 1);

        // STAGE1 -> STAGE2 mid-check: reload position, no pulse.
        start_req(DIR_RIGHT);
        @(posedge clk);
        #1;
        check("entry_busy_before", bus.busy, 1);
        set_state(ST_STAGE2);
        check("entry_x", bus.player_x, 1);
        check("entry_y", bus.player_y, 1);
        check("entry_busy", bus.busy, 0);
        count_done(8, cnt);
        check("entry_no_done", cnt, 0);

        // Three committed moves and one blocked move.
        do_move(DIR_RIGHT, 6'd2, 6'd1, 1'b0, 5);
        do_move(DIR_RIGHT, 6'd3, 6'd1, 1'b0, 5);
        do_move(DIR_RIGHT, 6'd4, 6'd1, 1'b0, 5);
        do_move(DIR_UP,    6'd4, 6'd1, 1'b1, 5);
`ifdef PLAYER_MOVE_STEP_COUNT_EN
        check("step_count_3", bus.step_count, 3);
`endif
        set_state(ST_STAGE3);
        check("stage3_x", bus.player_x, 1);
`ifdef PLAYER_MOVE_STEP_COUNT_EN
        check("step_count_entry", bus.step_count, 0);
`endif

        // Reset asserted mid-check: outputs return to reset values at once.
        do_move(DIR_RIGHT, 6'd2, 6'd1, 1'b0, 5);
        do_move(DIR_RIGHT, 6'd3, 6'd1, 1'b0, 5);
        start_req(DIR_DOWN);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_mid_x", bus.player_x, 1);
        check("rst_mid_y", bus.player_y, 1);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_done", bus.move_done, 0);
        check("rst_mid_blocked", bus.blocked, 0);
`ifdef PLAYER_MOVE_STEP_COUNT_EN
        check("rst_mid_steps", bus.step_count, 0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        count_done(8, cnt);
        check("rst_no_done", cnt, 0);

        // Post-reset move still works from the start position.
        do_move(DIR_DOWN, 6'd1, 6'd2, 1'b0, 5);

        repeat (2) @(posedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
